fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the immediate extend unit and the decoder.
- Holds the architectural PC and issues single-outstanding read requests to instruction memory.
- Captures the returned word and presents Instr to decode/extend with a valid/ready handshake.
- Consumes the branch/jump target (PC + ImmExt) fed back from execute to redirect fetch.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_next_pc.sv | 39 +++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (HALT is reachable only when the
//                   FETCH_MISALIGN_CHK_EN macro is defined)
//   NOP_INSTR     : instruction presented to decode while nothing has been
//                   fetched yet (addi x0, x0, 0)
//   INSTR_BYTES   : size of one instruction word, i.e. the sequential PC step
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_next_pc.sv
// ----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-fetch-address selection.
//   i_pc          : address of the instruction currently held for decode
//   i_pc_src      : 1 = take the redirect from execute
//   i_pc_target   : redirect address from execute
//   o_next_pc     : sequential PC (i_pc + 4, wraps mod 2^32) or the
//                   word-aligned redirect target
//   o_misalign    : (only with FETCH_MISALIGN_CHK_EN) redirect requested to
//                   an address that is not word aligned
// Macro: FETCH_MISALIGN_CHK_EN adds the o_misalign output.
// ----------------------------------------------------------------------------
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_src,
    input  logic [XLEN-1:0] i_pc_target,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            o_misalign,
`endif
    output logic [XLEN-1:0] o_next_pc
);

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_aligned_target;

    assign w_seq_pc         = i_pc + INSTR_BYTES;
    // Low two bits are dropped so the fetch address is always word aligned.
    assign w_aligned_target = i_pc_target & ~32'd3;
    assign o_next_pc        = i_pc_src ? w_aligned_target : w_seq_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    assign o_misalign = i_pc_src && (i_pc_target[1:0] != 2'b00);
`endif

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: holds the architectural fetch PC, issues one
// outstanding read to instruction memory at a time, and presents the
// returned word to decode/extend with a valid/ready handshake. A redirect
// (PCSrc/PCTarget) is taken only when decode accepts the held instruction.
//
// Ports:
//   CLK, RST        clock; asynchronous active-high reset
//   imem_req_valid  out  read request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   read data valid (ignored unless waiting for it)
//   imem_rsp_data   in   fetched instruction word
//   instr_valid     out  Instr/PC valid to decode
//   instr_ready     in   decode accepts current instruction
//   Instr           out  instruction word
//   PC              out  address of Instr
//   PCPlus4         out  PC + 4
//   PCSrc           in   take redirect (sampled on instr_valid && instr_ready)
//   PCTarget        in   redirect address
//   misalign_fault  out  (FETCH_MISALIGN_CHK_EN only) sticky misaligned
//                        redirect flag; fetch halts until reset
//
// Macro: FETCH_MISALIGN_CHK_EN enables misalign_fault and the HALT state.
// Only XLEN = 32 is supported.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic            misalign_fault,
`endif
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_req_valid;
    logic            r_instr_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            r_misalign_fault;
    logic            w_misalign;
`endif

    fetch_next_pc #(
        .XLEN (XLEN)
    ) u_next_pc (
        .i_pc        (r_pc),
        .i_pc_src    (PCSrc),
        .i_pc_target (PCTarget),
`ifdef FETCH_MISALIGN_CHK_EN
        .o_misalign  (w_misalign),
`endif
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_PC;
            r_pc_plus4    <= RESET_PC + INSTR_BYTES;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_valid <= 1'b1;
                    r_state     <= REQ;
                end
                REQ: begin
                    // Address is r_fetch_pc, which cannot change here, so it
                    // stays stable for as long as the request is stalled.
                    if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        r_instr       <= imem_rsp_data;
                        r_pc          <= r_fetch_pc;
                        r_pc_plus4    <= r_fetch_pc + INSTR_BYTES;
                        r_instr_valid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                        if (w_misalign) begin
                            r_misalign_fault <= 1'b1;
                            r_state          <= HALT;
                        end else
`endif
                        begin
                            r_fetch_pc  <= w_next_pc;
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                HALT: begin
                    // Terminal until reset: no requests, nothing to decode.
                    r_state <= HALT;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = r_instr_valid;
    assign Instr          = r_instr;
    assign PC             = r_pc;
    assign PCPlus4        = r_pc_plus4;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_fault = r_misalign_fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A transaction-level model tracks the
// fetch address, the outstanding request, and the instruction held for
// decode; every cycle the DUT outputs are compared with it. Directed
// sequences pin the model with literal values; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        PCSrc    = 1'b0;
    logic [31:0] PCTarget = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_fault;
`endif

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
`ifdef FETCH_MISALIGN_CHK_EN
        .misalign_fault (misalign_fault),
`endif
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state.
    bit          m_boot;        // first edge after reset launches a request
    bit          m_req_valid;   // a request is being offered
    bit          m_outstanding; // request accepted, response not yet seen
    bit          m_instr_valid; // an instruction is held for decode
    bit          m_halt;
    bit          m_fault;
    logic [31:0] m_fetch;       // address of the next/current request
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    int rsp_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot        = 1'b1;
        m_req_valid   = 1'b0;
        m_outstanding = 1'b0;
        m_instr_valid = 1'b0;
        m_halt        = 1'b0;
        m_fault       = 1'b0;
        m_fetch       = RESET_PC;
        m_instr       = NOP;
        m_pc          = RESET_PC;
    endtask

    task automatic compare();
        check("req_valid",   {31'b0, imem_req_valid}, {31'b0, m_req_valid});
        check("req_addr",    imem_req_addr, m_fetch);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_instr_valid});
        check("Instr",       Instr, m_instr);
        check("PC",          PC, m_pc);
        check("PCPlus4",     PCPlus4, m_pc + 32'd4);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_fault", {31'b0, misalign_fault}, {31'b0, m_fault});
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the handshakes those
    // inputs produce at the next rising edge, then compare after the edge.
    task automatic cycle(input logic ready, input logic rspv, input logic [31:0] rspd,
                         input logic iready, input logic pcsrc, input logic [31:0] tgt);
        bit take_req, take_rsp, take_instr;
        imem_req_ready = ready;
        imem_rsp_valid = rspv;
        imem_rsp_data  = rspd;
        instr_ready    = iready;
        PCSrc          = pcsrc;
        PCTarget       = tgt;

        take_req   = m_req_valid && ready;
        take_rsp   = m_outstanding && rspv;
        take_instr = m_instr_valid && iready;

        if (m_boot) begin
            m_boot      = 1'b0;
            m_req_valid = 1'b1;
        end
        if (take_req) begin
            m_req_valid   = 1'b0;
            m_outstanding = 1'b1;
        end
        if (take_rsp) begin
            m_outstanding = 1'b0;
            m_instr       = rspd;
            m_pc          = m_fetch;
            m_instr_valid = 1'b1;
        end
        if (take_instr) begin
            m_instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (pcsrc && (tgt % 4 != 0)) begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end
`endif
            if (!m_halt) begin
                m_fetch     = pcsrc ? (tgt - (tgt % 4)) : (m_pc + 32'd4);
                m_req_valid = 1'b1;
            end
        end

        @(posedge CLK);
        #1;
        compare();
    endtask

    task automatic do_reset();
        RST            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        PCSrc          = 1'b0;
        model_reset();
        #1;
        compare();                 // reset must act without a clock edge
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic accept_req();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask
    task automatic give_rsp(input logic [31:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0);
    endtask
    task automatic take(input logic pcsrc, input logic [31:0] tgt);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, pcsrc, tgt);
    endtask

    initial begin
        #2;
        do_reset();

        // Boot fetch.
        accept_req();                    // IDLE -> REQ
        check("boot_addr", imem_req_addr, 32'h0);
        accept_req();                    // REQ -> WAIT
        give_rsp(32'h0050_0093);
        check("boot_instr",   Instr, 32'h0050_0093);
        check("boot_pc",      PC, 32'h0);
        check("boot_pcplus4", PCPlus4, 32'h4);

        // Decode backpressure, then sequential fetch from 0x4.
        repeat (5) cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h80);
        check("bp_no_req", {31'b0, imem_req_valid}, 32'h0);
        take(1'b0, 32'h0);
        check("seq_addr", imem_req_addr, 32'h4);
        check("seq_req",  {31'b0, imem_req_valid}, 32'h1);

        // Fetch 0x4, then 0x8, then redirect to 0x40.
        accept_req();
        give_rsp(32'h0010_0113);
        take(1'b0, 32'h0);
        accept_req();
        give_rsp(32'h0020_0193);
        check("pc8", PC, 32'h8);
        take(1'b1, 32'h40);
        check("redir_addr", imem_req_addr, 32'h40);

        // Memory stall for 3 cycles in REQ.
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("stall_addr", imem_req_addr, 32'h40);
        accept_req();
        check("stall_wait", {31'b0, imem_req_valid}, 32'h0);
        give_rsp(32'h00A0_0213);
        check("redir_pc",      PC, 32'h40);
        check("redir_pcplus4", PCPlus4, 32'h44);

        // Wrap of PC + 4 at the top of the address space.
        take(1'b1, 32'hFFFF_FFFC);
        accept_req();
        give_rsp(32'h0000_0013);
        check("wrap_pcplus4", PCPlus4, 32'h0);
        take(1'b0, 32'h0);
        check("wrap_addr", imem_req_addr, 32'h0);

        // Misaligned redirect.
        accept_req();
        give_rsp(32'h0000_0013);
        take(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_fault_set", {31'b0, misalign_fault}, 32'h1);
        repeat (4) cycle(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("halt_no_req", {31'b0, imem_req_valid}, 32'h0);
`else
        check("misalign_addr", imem_req_addr, 32'h40);
`endif

        // Mid-operation reset while waiting, then a stale response.
        do_reset();
        accept_req();
        accept_req();                    // now waiting for a response
        RST = 1'b1;
        #1;
        check("mid_rst_req",   {31'b0, imem_req_valid}, 32'h0);
        check("mid_rst_instr", Instr, NOP);
        #1;
        RST = 1'b1;
        do_reset();
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("stale_instr", Instr, NOP);
        check("stale_addr",  imem_req_addr, RESET_PC);

        // Randomized phase.
        rsp_delay = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        rdy, rspv, irdy, psrc;
            logic [31:0] rspd, tgt;
            bit          was_out;
            if (i == 1500) begin
                do_reset();
                rsp_delay = 0;
            end
            was_out = m_outstanding;
            rdy  = ($urandom % 3) != 0;
            rspd = $urandom;
            rspv = 1'b0;
            if (m_outstanding) begin
                if (rsp_delay == 0) rspv = 1'b1;
                else rsp_delay--;
            end else if ($urandom % 8 == 0) begin
                rspv = 1'b1;             // stray response must be ignored
            end
            irdy = ($urandom % 2) != 0;
            psrc = ($urandom % 4) == 0;
            tgt  = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
            tgt  = tgt & ~32'd3;
`endif
            cycle(rdy, rspv, rspd, irdy, psrc, tgt);
            if (!was_out && m_outstanding) rsp_delay = $urandom_range(0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
